cnn_frame_streamer: RTL and testbench
=====================================

// Module: cnn_frame_streamer
// PURPOSE
//  Downstream of the 28x28 box downsampler. On a user classify request, waits for the next
//  downsampler frame_done and snapshots the full 784-pixel image in one cycle. It then streams
//  the pixels to the CNN accelerator in raster order over a valid/ready handshake.
//  Decouples the CNN from the video timing: the streamed image is stable while VGA keeps drawing.
// PARAMETERS
//  NUM_PIXELS  784  pixels per image (28x28), raster order, index = row*28+col
//  PIXEL_W     6    bits per pixel (inverted/thresholded intensity from downsampler)
//  IDX_W       10   width of pixel index; must satisfy 2**IDX_W >= NUM_PIXELS
// PORTS
//  clk         in   1                    system/pixel clock, single domain
//  reset       in   1                    synchronous, active-high
//  frame_in    in   PIXEL_W x NUM_PIXELS unpacked array [0:NUM_PIXELS-1] from the downsampler
//  frame_done  in   1                    1-cycle pulse; frame_in complete and valid this cycle
//  start       in   1                    classify request (level or pulse); arms the capture
//  abort       in   1                    cancel any capture/stream, return to IDLE
//  out_pixel   out  PIXEL_W              current pixel value
//  out_index   out  IDX_W                index of out_pixel
//  out_valid   out  1                    out_pixel/out_index/out_last are valid
//  out_last    out  1                    high with the beat at index NUM_PIXELS-1
//  out_ready   in   1                    consumer accepts the beat when out_valid && out_ready
//  busy        out  1                    high in ARMED or STREAM
//  done        out  1                    1-cycle pulse the cycle after the last beat is accepted
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_last=0, out_index=0, out_pixel=0, busy=0, done=0.
//    Snapshot contents are undefined.
//  States:
//   - IDLE:   start=1 -> ARMED.
//   - ARMED:  frame_done=1 -> copy frame_in into snap[] on that edge; idx<=0; -> STREAM.
//             Capture latency is 1 cycle. out_valid rises the cycle after frame_done.
//   - STREAM: out_valid=1; out_pixel=snap[idx]; out_index=idx; out_last=(idx==NUM_PIXELS-1).
//             Beat accepted (valid&&ready): idx<=idx+1 if not last.
//             If last: -> IDLE, done<=1, out_valid<=0.
//  Outputs are registered; no combinational path from out_ready to out_valid/out_pixel.
//  Throughput is 1 beat/cycle with out_ready held high, so the frame takes NUM_PIXELS cycles.
//  AXI-style stability: once out_valid=1, out_pixel/out_index/out_last hold until accepted.
//    The valid signal is never dropped without acceptance, except on abort or reset.
//  Ignored events:
//   - frame_done in IDLE or STREAM (frame dropped).
//   - start in ARMED or STREAM.
//   - A new frame never overwrites snap[] mid-stream.
//  Simultaneous events:
//   - start and frame_done in the same cycle in IDLE: go to ARMED only; wait for the next frame.
//   - Last beat accepted while start=1: go to IDLE; start is seen the following cycle.
//  abort has priority over all transitions: next state IDLE, out_valid=0, done=0.
//  reset mid-stream behaves identically to abort. No partial done pulse.
//  idx never exceeds NUM_PIXELS-1. There is no wrap-around.
// STRUCTURE
//  Shared package cnn_pkg:
//   - typedef enum logic [1:0] {S_IDLE, S_ARMED, S_STREAM} stream_state_t
//   - localparams IMG_DIM=28, NUM_PIXELS=784, PIXEL_W=6
//   - typedef logic [PIXEL_W-1:0] pixel_t
//  Single module with no sub-module.
//   - snap[] is a register array written in parallel. It must not be inferred as BRAM,
//     because the write is a 784-wide parallel load.
//   - Output is a registered mux snap[idx].
// TESTING
//  1. start pulse, then frame_done with frame_in[i]=i%64, out_ready=1:
//     out_valid rises 1 cycle after frame_done; 784 beats out_pixel=i%64 at out_index=i;
//     out_last only on beat 783; done pulses once.
//  2. out_ready toggled pseudo-randomly:
//     same 784 beats in order; out_pixel/out_index stable while valid && !ready.
//  3. frame_done with no start, then start, then second frame_done with different data:
//     only the second frame is streamed.
//  4. Mid-stream (beat 300), change frame_in and pulse frame_done:
//     beats 300..783 still carry the original snapshot values.
//  5. abort at beat 100 (and separately reset at beat 100):
//     out_valid=0 next cycle, busy=0, no done; a new start+frame_done streams from index 0.
//  6. start and frame_done in the same cycle from IDLE:
//     no stream until the next frame_done; busy=1 in between.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and image geometry for the CNN front end (downsampler -> streamer -> accelerator).
package cnn_pkg;

    localparam int IMG_DIM    = 28;
    localparam int NUM_PIXELS = IMG_DIM * IMG_DIM;
    localparam int PIXEL_W    = 6;
    localparam int IDX_W      = 10;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_STREAM
    } stream_state_t;

endpackage

// File: rtl/cnn_frame_streamer.sv
// Snapshots one downsampled 28x28 frame on request and streams it in raster order over
// valid/ready, so the CNN sees a stable image regardless of the video timing.
module cnn_frame_streamer #(
    parameter int NUM_PIXELS = cnn_pkg::NUM_PIXELS,
    parameter int PIXEL_W    = cnn_pkg::PIXEL_W,
    parameter int IDX_W      = cnn_pkg::IDX_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIXEL_W-1:0] frame_in [0:NUM_PIXELS-1],
    input  logic               frame_done,
    input  logic               start,
    input  logic               abort,
    output logic [PIXEL_W-1:0] out_pixel,
    output logic [IDX_W-1:0]   out_index,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);
    import cnn_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

    stream_state_t      state;
    stream_state_t      next_state;
    logic [PIXEL_W-1:0] snap [0:NUM_PIXELS-1];
    logic               capture;
    logic               accept;
    logic               last_accept;
    logic [IDX_W-1:0]   next_idx;

    // abort overrides every transition and suppresses capture, beat advance and done
    always_comb begin
        next_state  = state;
        capture     = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        next_idx    = out_index + IDX_W'(1);
        case (state)
            S_IDLE: begin
                if (start) next_state = S_ARMED;
            end
            S_ARMED: begin
                if (frame_done) begin
                    capture    = 1'b1;
                    next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_valid && out_ready) begin
                    accept = 1'b1;
                    if (out_last) begin
                        last_accept = 1'b1;
                        next_state  = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (abort) begin
            next_state  = S_IDLE;
            capture     = 1'b0;
            accept      = 1'b0;
            last_accept = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Plain flops with a full-width parallel load; contents are don't-care until captured.
    always_ff @(posedge clk) begin
        if (capture && !reset) snap <= frame_in;
    end

    // Beat 0 comes straight from frame_in because snap is being loaded on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            out_pixel <= '0;
            done      <= 1'b0;
        end else begin
            done <= last_accept;
            if (abort) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (capture) begin
                out_valid <= 1'b1;
                out_pixel <= frame_in[0];
                out_index <= '0;
                out_last  <= (LAST_IDX == '0);
            end else if (last_accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (accept) begin
                out_pixel <= snap[next_idx];
                out_index <= next_idx;
                out_last  <= (next_idx == LAST_IDX);
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Randomised bench for cnn_frame_streamer: a frame-level model of the request/capture/stream
// behaviour is compared against the DUT on every cycle, with literal pins on key timings.
module tb_cnn_frame_streamer;
    import cnn_pkg::*;

    localparam int NP = NUM_PIXELS;

    logic             clk        = 1'b0;
    logic             reset      = 1'b1;
    pixel_t           frame_in [0:NP-1];
    logic             frame_done = 1'b0;
    logic             start      = 1'b0;
    logic             abort      = 1'b0;
    pixel_t           out_pixel;
    logic [IDX_W-1:0] out_index;
    logic             out_valid;
    logic             out_last;
    logic             out_ready  = 1'b1;
    logic             busy;
    logic             done;

    int passCount  = 0;
    int checkCount = 0;

    int m_mode   = 0;
    int m_beat   = 0;
    int m_done   = 0;
    int model_ok = 0;
    int m_img [0:NP-1];

    int doneCount = 0;
    int lastCount = 0;
    int lastPix   = -1;
    int prevHold  = 0;
    int prevPix   = 0;
    int prevIdx   = 0;
    bit randReady = 1'b0;

    always #5 clk = ~clk;

    cnn_frame_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .frame_in   (frame_in),
        .frame_done (frame_done),
        .start      (start),
        .abort      (abort),
        .out_pixel  (out_pixel),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    endtask

    // Mode: 0 idle, 1 waiting for a frame, 2 streaming m_img from beat m_beat.
    always @(negedge clk) begin
        if (model_ok != 0) begin
            checkOutput("valid", int'(out_valid), int'(m_mode == 2));
            checkOutput("busy", int'(busy), int'(m_mode != 0));
            checkOutput("done", int'(done), m_done);
            if (m_mode == 2) begin
                checkOutput("pixel", int'(out_pixel), m_img[m_beat]);
                checkOutput("index", int'(out_index), m_beat);
                checkOutput("last", int'(out_last), int'(m_beat == NP - 1));
            end
            if (prevHold != 0 && out_valid) begin
                checkOutput("hold_pixel", int'(out_pixel), prevPix);
                checkOutput("hold_index", int'(out_index), prevIdx);
            end
            if (done) doneCount++;
            if (out_valid && out_ready && out_last) begin
                lastCount++;
                lastPix = int'(out_pixel);
            end
        end
        prevHold = int'(out_valid && !out_ready && !abort && !reset);
        prevPix  = int'(out_pixel);
        prevIdx  = int'(out_index);
        m_done   = 0;
        if (reset) begin
            model_ok = 1;
            m_mode   = 0;
        end else if (abort) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (frame_done) begin
                for (int i = 0; i < NP; i++) m_img[i] = int'(frame_in[i]);
                m_beat = 0;
                m_mode = 2;
            end
        end else if (out_ready) begin
            if (m_beat == NP - 1) begin
                m_mode = 0;
                m_done = 1;
            end else begin
                m_beat++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic applyStimulus(input bit s, input bit fd, input bit ab, input bit rs);
        @(posedge clk); #1;
        start      = s;
        frame_done = fd;
        abort      = ab;
        reset      = rs;
        @(posedge clk); #1;
        start      = 1'b0;
        frame_done = 1'b0;
        abort      = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic fillFrame(input bit ramp);
        for (int i = 0; i < NP; i++)
            frame_in[i] = ramp ? pixel_t'(i % 64) : pixel_t'($urandom_range(0, 63));
    endtask

    task automatic waitDone(input int maxCycles);
        int n = 0;
        while (!done && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (!done) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic waitBeat(input int beat);
        int n = 0;
        while (!(m_mode == 2 && m_beat >= beat) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(m_mode == 2 && m_beat >= beat)) checkOutput("beat_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int first;
        fillFrame(1'b1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid", int'(out_valid), 0);
        checkOutput("rst_last", int'(out_last), 0);
        checkOutput("rst_index", int'(out_index), 0);
        checkOutput("rst_pixel", int'(out_pixel), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);

        $display("[TB] ramp frame, ready held high");
        doneCount = 0;
        lastCount = 0;
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("s1_first_valid", int'(out_valid), 1);
        checkOutput("s1_first_pixel", int'(out_pixel), 0);
        checkOutput("s1_first_index", int'(out_index), 0);
        n = 1;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("s1_done_latency", n, 785);
        repeat (3) @(posedge clk);
        checkOutput("s1_done_pulses", doneCount, 1);
        checkOutput("s1_last_beats", lastCount, 1);
        checkOutput("s1_last_pixel", lastPix, 15);

        $display("[TB] random frame, random backpressure");
        randReady = 1'b1;
        fillFrame(1'b0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        waitDone(10000);
        randReady = 1'b0;

        $display("[TB] frame_done while idle is dropped");
        fillFrame(1'b0);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("s3_idle_busy", int'(busy), 0);
        checkOutput("s3_idle_valid", int'(out_valid), 0);
        applyStimulus(1, 0, 0, 0);
        fillFrame(1'b0);
        first = int'(frame_in[0]);
        applyStimulus(0, 1, 0, 0);
        @(negedge clk);
        checkOutput("s3_second_frame_pixel", int'(out_pixel), first);
        waitDone(2000);

        $display("[TB] new frame mid-stream does not disturb snapshot");
        randReady = 1'b1;
        fillFrame(1'b0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        waitBeat(300);
        fillFrame(1'b0);
        applyStimulus(0, 1, 0, 0);
        waitDone(10000);
        randReady = 1'b0;

        for (int k = 0; k < 2; k++) begin
            $display("[TB] cancel at beat 100 via %s", (k == 0) ? "abort" : "reset");
            fillFrame(1'b0);
            applyStimulus(1, 0, 0, 0);
            applyStimulus(0, 1, 0, 0);
            waitBeat(100);
            doneCount = 0;
            applyStimulus(0, 0, k == 0, k == 1);
            @(negedge clk);
            checkOutput("s5_cancel_valid", int'(out_valid), 0);
            checkOutput("s5_cancel_busy", int'(busy), 0);
            checkOutput("s5_cancel_done", int'(done), 0);
            if (k == 1) begin
                checkOutput("s5_reset_index", int'(out_index), 0);
                checkOutput("s5_reset_pixel", int'(out_pixel), 0);
            end
            repeat (900) @(negedge clk);
            checkOutput("s5_no_done", doneCount, 0);
            fillFrame(1'b0);
            applyStimulus(1, 0, 0, 0);
            applyStimulus(0, 1, 0, 0);
            @(negedge clk);
            checkOutput("s5_restart_index", int'(out_index), 0);
            checkOutput("s5_restart_valid", int'(out_valid), 1);
            waitDone(2000);
        end

        $display("[TB] start and frame_done together");
        fillFrame(1'b0);
        applyStimulus(1, 1, 0, 0);
        repeat (5) begin
            @(negedge clk);
            checkOutput("s6_armed_busy", int'(busy), 1);
            checkOutput("s6_armed_valid", int'(out_valid), 0);
        end
        fillFrame(1'b0);
        applyStimulus(0, 1, 0, 0);
        waitDone(2000);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
